// File: rtl/lsq_pkg.sv
// Shared constants and helpers for the load/store queue: opcodes, access widths,
// FSM states and the tag/extension functions used by the queue and its picker.
package lsq_pkg;

  localparam logic [6:0] OP_LB  = 7'd11;
  localparam logic [6:0] OP_LH  = 7'd12;
  localparam logic [6:0] OP_LW  = 7'd13;
  localparam logic [6:0] OP_LBU = 7'd14;
  localparam logic [6:0] OP_LHU = 7'd15;
  localparam logic [6:0] OP_SB  = 7'd16;
  localparam logic [6:0] OP_SH  = 7'd17;
  localparam logic [6:0] OP_SW  = 7'd18;

  localparam logic [1:0] WID_BYTE = 2'd0;
  localparam logic [1:0] WID_HALF = 2'd1;
  localparam logic [1:0] WID_WORD = 2'd2;

  localparam logic [31:0] IO_BASE_DEFAULT = 32'h0003_0000;

  typedef enum logic {S_IDLE, S_WAIT_MEM} lsq_state_t;

  // NON_DEP is the tag with only the bit above the RoB index set.
  function automatic logic [31:0] non_dep_tag(input int unsigned rob_w);
    return 32'd1 << rob_w;
  endfunction

  function automatic logic is_store(input logic [6:0] op);
    return op >= OP_SB;
  endfunction

  function automatic logic [1:0] op_width(input logic [6:0] op);
    case (op)
      OP_LB, OP_LBU, OP_SB: return WID_BYTE;
      OP_LH, OP_LHU, OP_SH: return WID_HALF;
      OP_LW, OP_SW:         return WID_WORD;
      default:              return WID_WORD;
    endcase
  endfunction

  function automatic logic [31:0] load_extend(input logic [6:0] op, input logic [31:0] d);
    case (op)
      OP_LB:   return {{24{d[7]}}, d[7:0]};
      OP_LBU:  return {24'b0, d[7:0]};
      OP_LH:   return {{16{d[15]}}, d[15:0]};
      OP_LHU:  return {16'b0, d[15:0]};
      OP_LW:   return d;
      default: return d;
    endcase
  endfunction

endpackage

// File: rtl/lsq_age_picker.sv
// Picks the oldest eligible slot, age measured from the queue head pointer.
module lsq_age_picker
  import lsq_pkg::*;
#(
  parameter int unsigned LSQ_WIDTH = 3
) (
  input  logic [2**LSQ_WIDTH-1:0] elig_i,
  input  logic [LSQ_WIDTH-1:0]    head_i,
  output logic                    valid_o,
  output logic [LSQ_WIDTH-1:0]    idx_o
);
  localparam int unsigned DEPTH = 2**LSQ_WIDTH;

  logic [LSQ_WIDTH-1:0] slot;

  // Scan youngest to oldest so the last hit kept is the oldest.
  always_comb begin
    valid_o = 1'b0;
    idx_o   = head_i;
    slot    = '0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      slot = head_i + LSQ_WIDTH'(k);
      if (elig_i[slot]) begin
        valid_o = 1'b1;
        idx_o   = slot;
      end
    end
  end

endmodule

// File: rtl/load_store_queue.sv
// Circular load/store queue: in-order stores at RoB head, out-of-order loads with
// store-to-load forwarding, one outstanding memory request at a time.
module load_store_queue
  import lsq_pkg::*;
#(
  parameter int unsigned LSQ_WIDTH = 3,
  parameter int unsigned ROB_WIDTH = 4,
  parameter logic [31:0] IO_BASE   = IO_BASE_DEFAULT
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 rdy_in,
  input  logic                 flush_in,
  input  logic                 new_entry_en,
  input  logic [ROB_WIDTH-1:0] new_entry_rob_index,
  input  logic [6:0]           new_entry_opcode,
  input  logic [31:0]          new_entry_vj,
  input  logic [31:0]          new_entry_vk,
  input  logic [ROB_WIDTH:0]   new_entry_qj,
  input  logic [ROB_WIDTH:0]   new_entry_qk,
  input  logic [31:0]          new_entry_imm,
  input  logic                 cdb_en,
  input  logic [ROB_WIDTH-1:0] cdb_index,
  input  logic [31:0]          cdb_data,
  input  logic [ROB_WIDTH-1:0] rob_head_index,
  output logic                 mem_query_en,
  output logic                 mem_query_type,
  output logic [31:0]          mem_query_addr,
  output logic [31:0]          mem_query_data,
  output logic [1:0]           mem_data_width,
  input  logic                 mem_reply_en,
  input  logic [31:0]          mem_reply_data,
  output logic                 result_en,
  output logic [ROB_WIDTH-1:0] result_index,
  output logic [31:0]          result_data,
  output logic                 is_full
);
  localparam int unsigned DEPTH = 2**LSQ_WIDTH;
  typedef logic [LSQ_WIDTH-1:0] ptr_t;
  typedef logic [ROB_WIDTH:0]   tag_t;
  localparam tag_t NON_DEP = tag_t'(non_dep_tag(ROB_WIDTH));

  typedef struct packed {
    logic                 busy;
    logic [6:0]           op;
    logic [ROB_WIDTH-1:0] rob;
    logic [31:0]          vj;
    tag_t                 qj;
    logic [31:0]          vk;
    tag_t                 qk;
    logic [31:0]          imm;
  } entry_t;

  entry_t ent_q [DEPTH];
  entry_t ent_d [DEPTH];
  entry_t new_e;
  ptr_t head_q, head_d, tail_q, tail_d, cur_q, cur_d, pick_idx, jj;
  logic [LSQ_WIDTH:0] cnt_q, cnt_d;
  lsq_state_t state_q, state_d;
  logic mq_en_q, mq_en_d, mq_type_q, mq_type_d;
  logic [31:0] mq_addr_q, mq_addr_d, mq_data_q, mq_data_d;
  logic [1:0] mq_wid_q, mq_wid_d;
  logic res_en_q, res_en_d;
  logic [ROB_WIDTH-1:0] res_idx_q, res_idx_d;
  logic [31:0] res_data_q, res_data_d;

  ptr_t age [DEPTH];
  logic [31:0] addr [DEPTH];
  logic [31:0] fwd_data [DEPTH];
  logic [DEPTH-1:0] aready, ready, ld_elig, fwd_hit, fwd_rdy;
  logic blk, pick_vld, acc, adv;

  function automatic logic tag_hit(input tag_t q, input logic en, input logic [ROB_WIDTH-1:0] idx);
    return en && !q[ROB_WIDTH] && (q[ROB_WIDTH-1:0] == idx);
  endfunction

  // Operands captured from the CDB take priority over this block's own result.
  function automatic entry_t wake(input entry_t e, input logic c_en, input logic [ROB_WIDTH-1:0] c_idx,
                                  input logic [31:0] c_d, input logic r_en,
                                  input logic [ROB_WIDTH-1:0] r_idx, input logic [31:0] r_d);
    entry_t o = e;
    if (tag_hit(e.qj, c_en, c_idx))      begin o.vj = c_d; o.qj = NON_DEP; end
    else if (tag_hit(e.qj, r_en, r_idx)) begin o.vj = r_d; o.qj = NON_DEP; end
    if (tag_hit(e.qk, c_en, c_idx))      begin o.vk = c_d; o.qk = NON_DEP; end
    else if (tag_hit(e.qk, r_en, r_idx)) begin o.vk = r_d; o.qk = NON_DEP; end
    return o;
  endfunction

  assign is_full = (cnt_q == (LSQ_WIDTH+1)'(DEPTH));

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      age[i]    = ptr_t'(i) - head_q;
      addr[i]   = ent_q[i].vj + ent_q[i].imm;
      aready[i] = (ent_q[i].qj == NON_DEP);
      ready[i]  = aready[i] && (ent_q[i].qk == NON_DEP);
    end
  end

  // Walk older stores oldest-first so the youngest exact match supplies the data.
  always_comb begin
    blk = 1'b0;
    jj  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      blk         = 1'b0;
      fwd_hit[i]  = 1'b0;
      fwd_rdy[i]  = 1'b0;
      fwd_data[i] = '0;
      for (int k = 0; k < DEPTH; k++) begin
        jj = head_q + ptr_t'(k);
        if (ent_q[jj].busy && is_store(ent_q[jj].op) && (ptr_t'(k) < age[i])) begin
          if (!aready[jj]) blk = 1'b1;
          else if (addr[jj] == addr[i] && op_width(ent_q[jj].op) == op_width(ent_q[i].op)) begin
            fwd_hit[i]  = 1'b1;
            fwd_rdy[i]  = (ent_q[jj].qk == NON_DEP);
            fwd_data[i] = ent_q[jj].vk;
          end else if (addr[jj][31:2] == addr[i][31:2]) blk = 1'b1;
        end
      end
      ld_elig[i] = ent_q[i].busy && !is_store(ent_q[i].op) && ready[i] && !blk &&
                   (!fwd_hit[i] || fwd_rdy[i]) &&
                   ((addr[i] < IO_BASE) || (ent_q[i].rob == rob_head_index));
    end
  end

  lsq_age_picker #(.LSQ_WIDTH(LSQ_WIDTH)) u_picker (
    .elig_i  (ld_elig),
    .head_i  (head_q),
    .valid_o (pick_vld),
    .idx_o   (pick_idx)
  );

  always_comb begin
    head_d = head_q;  tail_d = tail_q;  cnt_d = cnt_q;  cur_d = cur_q;  state_d = state_q;
    mq_en_d = mq_en_q;  mq_type_d = mq_type_q;  mq_addr_d = mq_addr_q;
    mq_data_d = mq_data_q;  mq_wid_d = mq_wid_q;
    res_en_d = 1'b0;  res_idx_d = res_idx_q;  res_data_d = res_data_q;
    for (int i = 0; i < DEPTH; i++)
      ent_d[i] = ent_q[i].busy ? wake(ent_q[i], cdb_en, cdb_index, cdb_data, res_en_q, res_idx_q, res_data_q)
                               : ent_q[i];

    case (state_q)
      S_IDLE: begin
        if (ent_q[head_q].busy && is_store(ent_q[head_q].op) && ready[head_q] &&
            ent_q[head_q].rob == rob_head_index) begin
          mq_en_d = 1'b1;  mq_type_d = 1'b1;  mq_addr_d = addr[head_q];
          mq_data_d = ent_q[head_q].vk;  mq_wid_d = op_width(ent_q[head_q].op);
          cur_d = head_q;  state_d = S_WAIT_MEM;
        end else if (pick_vld && fwd_hit[pick_idx]) begin
          res_en_d = 1'b1;  res_idx_d = ent_q[pick_idx].rob;
          res_data_d = load_extend(ent_q[pick_idx].op, fwd_data[pick_idx]);
          ent_d[pick_idx].busy = 1'b0;
        end else if (pick_vld) begin
          mq_en_d = 1'b1;  mq_type_d = 1'b0;  mq_addr_d = addr[pick_idx];
          mq_data_d = '0;  mq_wid_d = op_width(ent_q[pick_idx].op);
          cur_d = pick_idx;  state_d = S_WAIT_MEM;
        end
      end
      S_WAIT_MEM: begin
        if (mem_reply_en) begin
          mq_en_d = 1'b0;  state_d = S_IDLE;
          res_en_d = 1'b1;  res_idx_d = ent_q[cur_q].rob;
          res_data_d = is_store(ent_q[cur_q].op) ? ent_q[cur_q].vk
                                                 : load_extend(ent_q[cur_q].op, mem_reply_data);
          ent_d[cur_q].busy = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase

    adv = (cnt_q != '0) && !ent_q[head_q].busy;
    acc = new_entry_en && !is_full;
    new_e = '{busy: 1'b1, op: new_entry_opcode, rob: new_entry_rob_index, vj: new_entry_vj,
              qj: new_entry_qj, vk: new_entry_vk, qk: new_entry_qk, imm: new_entry_imm};
    if (acc) begin
      ent_d[tail_q] = wake(new_e, cdb_en, cdb_index, cdb_data, res_en_q, res_idx_q, res_data_q);
      tail_d = tail_q + 1'b1;
    end
    if (adv) head_d = head_q + 1'b1;
    cnt_d = cnt_q + (LSQ_WIDTH+1)'(acc) - (LSQ_WIDTH+1)'(adv);

    if (flush_in) begin
      for (int i = 0; i < DEPTH; i++) ent_d[i].busy = 1'b0;
      head_d = '0;  tail_d = '0;  cnt_d = '0;  state_d = S_IDLE;
      mq_en_d = 1'b0;  res_en_d = 1'b0;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      head_q <= '0;  tail_q <= '0;  cnt_q <= '0;  cur_q <= '0;  state_q <= S_IDLE;
      mq_en_q <= 1'b0;  mq_type_q <= 1'b0;  mq_addr_q <= '0;  mq_data_q <= '0;  mq_wid_q <= '0;
      res_en_q <= 1'b0;  res_idx_q <= '0;  res_data_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        ent_q[i].busy <= 1'b0;
        ent_q[i].qj   <= NON_DEP;
        ent_q[i].qk   <= NON_DEP;
      end
    end else if (rdy_in) begin
      head_q <= head_d;  tail_q <= tail_d;  cnt_q <= cnt_d;  cur_q <= cur_d;  state_q <= state_d;
      mq_en_q <= mq_en_d;  mq_type_q <= mq_type_d;  mq_addr_q <= mq_addr_d;
      mq_data_q <= mq_data_d;  mq_wid_q <= mq_wid_d;
      res_en_q <= res_en_d;  res_idx_q <= res_idx_d;  res_data_q <= res_data_d;
      ent_q <= ent_d;
    end
  end

  assign mem_query_en   = mq_en_q;
  assign mem_query_type = mq_type_q;
  assign mem_query_addr = mq_addr_q;
  assign mem_query_data = mq_data_q;
  assign mem_data_width = mq_wid_q;
  assign result_en      = res_en_q;
  assign result_index   = res_idx_q;
  assign result_data    = res_data_q;

endmodule

// File: tb/tb_load_store_queue.sv
// Directed bench for load_store_queue with a result scoreboard and manual memory replies.
module tb_load_store_queue;
  import lsq_pkg::*;

  logic clk = 1'b0;
  logic rst, rdy, flush;
  logic ne_en;
  logic [3:0] ne_rob;
  logic [6:0] ne_op;
  logic [31:0] ne_vj, ne_vk, ne_imm;
  logic [4:0] ne_qj, ne_qk;
  logic c_en;
  logic [3:0] c_idx;
  logic [31:0] c_data;
  logic [3:0] rob_head;
  logic mq_en, mq_type;
  logic [31:0] mq_addr, mq_data;
  logic [1:0] mq_wid;
  logic mr_en;
  logic [31:0] mr_data;
  logic r_en;
  logic [3:0] r_idx;
  logic [31:0] r_data;
  logic full;

  localparam logic [4:0] ND = 5'b10000;

  typedef struct {
    logic [3:0]  idx;
    logic [31:0] data;
  } exp_t;
  exp_t sb[$];

  int total = 0;
  int bad = 0;
  int rd_cycles = 0;
  int n_res = 0;

  always #5 clk = ~clk;

  load_store_queue dut (
    .clk_in(clk), .rst_in(rst), .rdy_in(rdy), .flush_in(flush),
    .new_entry_en(ne_en), .new_entry_rob_index(ne_rob), .new_entry_opcode(ne_op),
    .new_entry_vj(ne_vj), .new_entry_vk(ne_vk), .new_entry_qj(ne_qj), .new_entry_qk(ne_qk),
    .new_entry_imm(ne_imm), .cdb_en(c_en), .cdb_index(c_idx), .cdb_data(c_data),
    .rob_head_index(rob_head), .mem_query_en(mq_en), .mem_query_type(mq_type),
    .mem_query_addr(mq_addr), .mem_query_data(mq_data), .mem_data_width(mq_wid),
    .mem_reply_en(mr_en), .mem_reply_data(mr_data), .result_en(r_en),
    .result_index(r_idx), .result_data(r_data), .is_full(full)
  );

  // Scoreboard monitor: every result pulse must match the oldest pending expectation.
  always @(negedge clk) begin
    if (!rst) begin
      if (mq_en && !mq_type) rd_cycles++;
      if (r_en) begin
        n_res++;
        total++;
        if (sb.size() == 0) begin
          assert (sb.size() != 0) else begin
            bad++;
            $error("FAIL unexpected_result: got idx=%0h data=%h want none", r_idx, r_data);
          end
        end else begin
          exp_t e;
          e = sb.pop_front();
          assert (r_idx === e.idx && r_data === e.data) else begin
            bad++;
            $error("FAIL result: got idx=%0h data=%h want idx=%0h data=%h", r_idx, r_data, e.idx, e.data);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic expect_res(input logic [3:0] idx, input logic [31:0] d);
    exp_t e;
    e.idx = idx;
    e.data = d;
    sb.push_back(e);
  endtask

  task automatic dispatch(input logic [6:0] op, input logic [3:0] rob, input logic [31:0] vj,
                          input logic [4:0] qj, input logic [31:0] vk, input logic [4:0] qk,
                          input logic [31:0] imm);
    ne_en = 1'b1; ne_op = op; ne_rob = rob; ne_vj = vj; ne_qj = qj;
    ne_vk = vk; ne_qk = qk; ne_imm = imm;
    tick();
    ne_en = 1'b0;
  endtask

  task automatic wait_req(input string tag);
    int n = 0;
    while (!mq_en && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 32'(mq_en), 32'd1);
  endtask

  task automatic reply(input logic [31:0] d);
    mr_en = 1'b1;
    mr_data = d;
    @(posedge clk);
    #1;
    mr_en = 1'b0;
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while (sb.size() != 0 && n < 50) begin
      tick();
      n++;
    end
    tick();
    chk(tag, 32'(sb.size()), 32'd0);
  endtask

  initial begin
    int rd0, res0;
    rst = 1'b1; rdy = 1'b0; flush = 1'b1;
    ne_en = 1'b0; ne_op = '0; ne_rob = '0; ne_vj = '0; ne_vk = '0; ne_imm = '0;
    ne_qj = ND; ne_qk = ND;
    c_en = 1'b0; c_idx = '0; c_data = '0; rob_head = '0; mr_en = 1'b0; mr_data = '0;
    repeat (3) tick();
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_mq_en", 32'(mq_en), 32'd0);
    chk("rst_res_en", 32'(r_en), 32'd0);
    chk("rst_mq_addr", mq_addr, 32'd0);
    rst = 1'b0; rdy = 1'b1; flush = 1'b0;
    tick();

    // Forwarding: sw 0x100 waits for commit, younger lw takes its data.
    rd0 = rd_cycles;
    expect_res(4'd2, 32'hDEADBEEF);
    dispatch(OP_SW, 4'd1, 32'h100, ND, 32'hDEADBEEF, ND, 32'd0);
    dispatch(OP_LW, 4'd2, 32'h100, ND, 32'd0, ND, 32'd0);
    drain("fwd_drain");
    chk("fwd_no_read", 32'(rd_cycles - rd0), 32'd0);
    rob_head = 4'd1;
    wait_req("st_req");
    chk("st_type", 32'(mq_type), 32'd1);
    chk("st_addr", mq_addr, 32'h100);
    chk("st_data", mq_data, 32'hDEADBEEF);
    expect_res(4'd1, 32'hDEADBEEF);
    reply(32'd0);
    drain("st_drain");

    // Sign and zero extension of byte loads.
    rob_head = 4'd3;
    expect_res(4'd3, 32'hFFFFFF80);
    dispatch(OP_LB, 4'd3, 32'h200, ND, 32'd0, ND, 32'd0);
    wait_req("lb_req");
    chk("lb_addr", mq_addr, 32'h200);
    chk("lb_wid", 32'(mq_wid), 32'd0);
    reply(32'h0000_0080);
    drain("lb_drain");
    expect_res(4'd4, 32'h00000080);
    dispatch(OP_LBU, 4'd4, 32'h1F0, ND, 32'd0, ND, 32'h10);
    wait_req("lbu_req");
    reply(32'h0000_0080);
    drain("lbu_drain");

    // Partial overlap blocks the load until the store completes.
    rob_head = 4'd0;
    rd0 = rd_cycles;
    dispatch(OP_SH, 4'd5, 32'h102, ND, 32'h1234, ND, 32'd0);
    dispatch(OP_LW, 4'd6, 32'h100, ND, 32'd0, ND, 32'd0);
    repeat (5) tick();
    chk("blk_no_req", 32'(mq_en), 32'd0);
    rob_head = 4'd5;
    wait_req("sh_req");
    chk("sh_type", 32'(mq_type), 32'd1);
    chk("sh_addr", mq_addr, 32'h102);
    chk("sh_wid", 32'(mq_wid), 32'd1);
    expect_res(4'd5, 32'h1234);
    reply(32'd0);
    expect_res(4'd6, 32'hCAFEF00D);
    wait_req("blk_ld_req");
    chk("blk_ld_type", 32'(mq_type), 32'd0);
    chk("blk_ld_addr", mq_addr, 32'h100);
    reply(32'hCAFEF00D);
    drain("blk_drain");

    // I/O load waits until it is the RoB head.
    rob_head = 4'd0;
    dispatch(OP_LW, 4'd7, 32'h30000, ND, 32'd0, ND, 32'd0);
    repeat (5) tick();
    chk("io_no_req", 32'(mq_en), 32'd0);
    rob_head = 4'd7;
    expect_res(4'd7, 32'h11223344);
    wait_req("io_req");
    chk("io_addr", mq_addr, 32'h30000);
    reply(32'h11223344);
    drain("io_drain");

    // Base operand arrives over the CDB.
    rob_head = 4'd0;
    dispatch(OP_LW, 4'd8, 32'd0, 5'h09, 32'd0, ND, 32'd4);
    repeat (3) tick();
    chk("cdb_no_req", 32'(mq_en), 32'd0);
    c_en = 1'b1; c_idx = 4'd9; c_data = 32'h400;
    tick();
    c_en = 1'b0;
    expect_res(4'd8, 32'h55);
    wait_req("cdb_req");
    chk("cdb_addr", mq_addr, 32'h404);
    reply(32'h55);
    drain("cdb_drain");

    // Fill the queue, then flush while a store is outstanding.
    rob_head = 4'd0;
    for (int k = 1; k <= 7; k++)
      dispatch(OP_SW, 4'(k), 32'h1000 + 32'(4 * k), ND, 32'(k), ND, 32'd0);
    chk("full_7", 32'(full), 32'd0);
    dispatch(OP_SW, 4'd8, 32'h1020, ND, 32'd8, ND, 32'd0);
    chk("full_8", 32'(full), 32'd1);
    dispatch(OP_SW, 4'd9, 32'h1024, ND, 32'd9, ND, 32'd0);
    chk("full_9", 32'(full), 32'd1);
    rob_head = 4'd1;
    wait_req("fl_req");
    chk("fl_addr", mq_addr, 32'h1004);
    res0 = n_res;
    flush = 1'b1;
    rob_head = 4'd0;
    tick();
    flush = 1'b0;
    chk("fl_full", 32'(full), 32'd0);
    chk("fl_mq_en", 32'(mq_en), 32'd0);
    reply(32'hBAD0BAD0);
    repeat (5) tick();
    chk("fl_late_reply", 32'(n_res - res0), 32'd0);

    // Queue is usable after the flush.
    expect_res(4'd2, 32'h0000007F);
    dispatch(OP_LB, 4'd2, 32'h200, ND, 32'd0, ND, 32'd0);
    wait_req("post_req");
    reply(32'h0000007F);
    drain("post_drain");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/load_store_queue.md
LOAD_STORE_QUEUE -- requirements
Module: load_store_queue

Interface
REQ-001 Parameter LSQ_WIDTH, default 3: queue depth is 2**LSQ_WIDTH entries.
REQ-002 Parameter ROB_WIDTH, default 4: tag width; tag value 2**ROB_WIDTH (bit ROB_WIDTH set) means NON_DEP.
REQ-003 Parameter IO_BASE, default 32'h0003_0000: addresses >= IO_BASE are I/O.
REQ-004 Ports, one per line (name, direction, width, meaning):
- clk_in  in  1  clock; the block has one clock.
- rst_in  in  1  reset; synchronous, active-high.
- rdy_in  in  1  global enable; low freezes all state.
- flush_in  in  1  misprediction flush from RoB.
- new_entry_en  in  1  dispatch valid.
- new_entry_rob_index  in  ROB_WIDTH  destination RoB tag.
- new_entry_opcode  in  7  lb=11 lh=12 lw=13 lbu=14 lhu=15 sb=16 sh=17 sw=18.
- new_entry_vj / new_entry_vk  in  32  base / store data.
- new_entry_qj / new_entry_qk  in  ROB_WIDTH+1  producer tags.
- new_entry_imm  in  32  offset.
- cdb_en / cdb_index / cdb_data  in  1/ROB_WIDTH/32  broadcast.
- rob_head_index  in  ROB_WIDTH  oldest uncommitted tag.
- mem_query_en  out  1  request valid.
- mem_query_type  out  1  0 read, 1 write.
- mem_query_addr / mem_query_data  out  32/32  request address / write data.
- mem_data_width  out  2  0 byte, 1 half, 2 word.
- mem_reply_en / mem_reply_data  in  1/32  completion.
- result_en / result_index / result_data  out  1/ROB_WIDTH/32  completion to RoB/CDB.
- is_full  out  1  all entries busy.

Function
REQ-005 Circular FIFO by head/tail pointers, wrap modulo depth; accept on new_entry_en && !is_full; is_full combinational.
REQ-006 Same-cycle CDB hit on incoming qj/qk captures cdb_data and NON_DEP; a busy entry whose tag matches cdb_en or the block's own result_en also captures.
REQ-007 Entry address-ready when qj==NON_DEP; ready when qj and qk both NON_DEP.
REQ-008 Store issues only at head, ready, and rob_head_index==its tag.
REQ-009 Load eligible (out of order) when ready, every older busy store is address-ready, and, if address >= IO_BASE, its tag equals rob_head_index; oldest eligible load wins.
REQ-010 Forwarding: youngest older store with identical address and identical width supplies vk; if vk is not ready the load waits; result issued next cycle with no memory access.
REQ-011 Older store whose word address (addr[31:2]) matches but is not an exact address+width match blocks the load.
REQ-012 FSM IDLE->WAIT_MEM on issue; WAIT_MEM->IDLE on mem_reply_en; one outstanding request; mem_query_en held until reply.
REQ-013 Load result sign- or zero-extended per opcode; store result_data = stored vk.
REQ-014 result_en is a one-cycle pulse; completed entry is freed; head advances over freed entries, one per cycle.
REQ-015 Same-cycle dispatch and completion both take effect; freeing the tail-adjacent entry does not admit a dispatch in that cycle.
REQ-016 flush_in (rdy_in high) empties queue, returns FSM to IDLE, drops outstanding request, suppresses result_en; a reply arriving after flush is ignored.

Reset
REQ-017 On rst_in: pointers 0, all entries free, tags NON_DEP, FSM IDLE, all outputs 0, is_full 0.
REQ-018 Reset overrides rdy_in and flush_in.

Structure
REQ-019 Opcode constants, width codes, NON_DEP function, IO_BASE default live in shared package lsq_pkg.
REQ-020 One sub-module lsq_age_picker: oldest-eligible selection relative to head pointer.

Verification
REQ-021 lw x at 0x100 behind ready sw 0x100 data 0xDEADBEEF at RoB head -> load result 0xDEADBEEF, no read request.
REQ-022 lb at 0x200, reply 0x80 -> result_data 0xFFFFFF80; lbu -> 0x00000080.
REQ-023 sh 0x102 pending older, lw 0x100 -> load blocked until store writes, then read issued.
REQ-024 Load from 0x30000 not at RoB head -> no request until rob_head_index matches.
REQ-025 Fill 8 entries -> is_full 1; flush mid WAIT_MEM -> empty, late reply produces no result_en.
